// File: rtl/sram_model_param_pkg.sv
// Shared types and limits for the parametrised byte-lane SRAM model.
// Package sram_pkg: FSM states, lane width, legal parameter limits and error causes.
package sram_pkg;

  typedef enum logic {IDLE, REC} state_t;

  localparam int LANE_W       = 8;
  localparam int MAX_READ_LAT = 4;
  localparam int MAX_WR_REC   = 15;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_BUSY    = 2'd1,
    ERR_COLLIDE = 2'd2
  } err_cause_t;

  // A busy hit takes priority; both only ever set the same sticky flag.
  function automatic err_cause_t err_cause(input logic busy_hit, input logic collide);
    if (busy_hit) return ERR_BUSY;
    if (collide)  return ERR_COLLIDE;
    return ERR_NONE;
  endfunction

endpackage

// File: rtl/sram_model_param_if.sv
// Control/status side of the SRAM bus; the shared data bus io stays a plain inout port.
interface sram_model_param_if #(
  parameter int DW = 16,
  parameter int AW = 16
);
  import sram_pkg::*;

  localparam int NB = DW / LANE_W;

  logic          ce;
  logic          oe;
  logic          we;
  logic [NB-1:0] be;
  logic [AW-1:0] a;
  logic          ready;
  logic          rd_vld;
  logic          err;

  modport master (output ce, oe, we, be, a, input  ready, rd_vld, err);
  modport slave  (input  ce, oe, we, be, a, output ready, rd_vld, err);

endinterface

// File: rtl/sram_rd_pipe.sv
// Read-latency shift register of {valid, data, byte enables}; the last stage
// is the output stage.
module sram_rd_pipe #(
  parameter int DW    = 16,
  parameter int NB    = 2,
  parameter int DEPTH = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_vld,
  input  logic [DW-1:0] in_data,
  input  logic [NB-1:0] in_be,
  output logic          out_vld,
  output logic [DW-1:0] out_data,
  output logic [NB-1:0] out_be
);

  logic          vld  [DEPTH];
  logic [DW-1:0] data [DEPTH];
  logic [NB-1:0] bes  [DEPTH];

  // NOTE: sequential state uses non-blocking assignments so stages shift
  // together instead of the new entry racing through every stage at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        vld[i]  <= 1'b0;
        data[i] <= '0;
        bes[i]  <= '1;
      end
    end else begin
      vld[0]  <= in_vld;
      data[0] <= in_data;
      bes[0]  <= in_be;
      for (int i = 1; i < DEPTH; i++) begin
        vld[i]  <= vld[i-1];
        data[i] <= data[i-1];
        bes[i]  <= bes[i-1];
      end
    end
  end

  assign out_vld  = vld[DEPTH-1];
  assign out_data = data[DEPTH-1];
  assign out_be   = bes[DEPTH-1];

endmodule

// File: rtl/sram_model_param.sv
// Behavioural byte-lane SRAM with configurable width/depth/read latency, write recovery and
// sticky protocol-error flag. Define SRAM_STATS_EN to add saturating rd_cnt/wr_cnt outputs.
module sram_model_param
  import sram_pkg::*;
#(
  parameter int DW        = 16,
  parameter int AW        = 16,
  parameter int READ_LAT  = 1,
  parameter int WR_REC    = 0,
  parameter     INIT_FILE = ""
) (
  input  logic                clk,
  input  logic                rst_n,
  sram_model_param_if.slave   bus,
  inout  wire  [DW-1:0]       io
`ifdef SRAM_STATS_EN
  ,
  output logic [31:0]         rd_cnt,
  output logic [31:0]         wr_cnt
`endif
);

  localparam int NB   = DW / LANE_W;
  localparam int RC_W = $clog2(MAX_WR_REC + 1);

  if ((DW % LANE_W) != 0 || READ_LAT < 0 || READ_LAT > MAX_READ_LAT ||
      WR_REC < 0 || WR_REC > MAX_WR_REC) begin : g_bad_param
    $error("sram_model_param: illegal DW/READ_LAT/WR_REC");
  end

  // NOTE: the memory array is never reset; a reset only discards in-flight
  // operations and the stored contents survive it.
  logic [DW-1:0] mem [2**AW];

  state_t          state;
  logic [RC_W-1:0] rec_cnt;
  logic            ready_q;
  logic            err_q;
  logic            rd_acc;
  logic            wr_acc;
  logic            busy_hit;
  logic            collide;
  logic            out_vld;
  logic            drive_en;
  logic [DW-1:0]   drive_data;
  logic [NB-1:0]   drive_be;

  assign wr_acc   = !bus.ce && !bus.we && ready_q;
  assign rd_acc   = !bus.ce &&  bus.we && ready_q;
  assign busy_hit = !bus.ce && !ready_q;
  assign collide  = wr_acc && out_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      rec_cnt <= '0;
      ready_q <= 1'b1;
    end else begin
      case (state)
        IDLE: if (wr_acc && WR_REC > 0) begin
          state   <= REC;
          rec_cnt <= RC_W'(WR_REC);
          ready_q <= 1'b0;
        end
        REC: if (rec_cnt <= RC_W'(1)) begin
          state   <= IDLE;
          rec_cnt <= '0;
          ready_q <= 1'b1;
        end else begin
          rec_cnt <= rec_cnt - 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                   err_q <= 1'b0;
    else if (err_cause(busy_hit, collide) != ERR_NONE) err_q <= 1'b1;
  end

  // rst_n gates the write so a reset coinciding with an edge drops the access.
  always_ff @(posedge clk) begin
    if (rst_n && wr_acc) begin
      for (int i = 0; i < NB; i++) begin
        if (!bus.be[i]) mem[bus.a][i*LANE_W +: LANE_W] <= io[i*LANE_W +: LANE_W];
      end
    end
  end

  if (READ_LAT == 0) begin : g_comb
    assign out_vld    = 1'b0;
    assign drive_en   = !bus.ce && !bus.oe && bus.we;
    assign drive_data = mem[bus.a];
    assign drive_be   = bus.be;
  end else begin : g_pipe
    logic          pipe_vld;
    logic [DW-1:0] pipe_data;
    logic [NB-1:0] pipe_be;

    // Data is snapshotted at accept, so later writes cannot alter it.
    sram_rd_pipe #(.DW(DW), .NB(NB), .DEPTH(READ_LAT)) u_rd_pipe (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_vld   (rd_acc),
      .in_data  (mem[bus.a]),
      .in_be    (bus.be),
      .out_vld  (pipe_vld),
      .out_data (pipe_data),
      .out_be   (pipe_be)
    );

    assign out_vld    = pipe_vld;
    assign drive_en   = pipe_vld && !bus.oe && bus.we;
    assign drive_data = pipe_data;
    assign drive_be   = pipe_be;
  end

  for (genvar i = 0; i < NB; i++) begin : g_lane
    assign io[i*LANE_W +: LANE_W] = (drive_en && !drive_be[i]) ?
                                    drive_data[i*LANE_W +: LANE_W] : {LANE_W{1'bz}};
  end

  assign bus.ready  = ready_q;
  assign bus.rd_vld = drive_en;
  assign bus.err    = err_q;

`ifdef SRAM_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_cnt <= '0;
      wr_cnt <= '0;
    end else begin
      if (rd_acc && rd_cnt != 32'hFFFF_FFFF) rd_cnt <= rd_cnt + 1'b1;
      if (wr_acc && wr_cnt != 32'hFFFF_FFFF) wr_cnt <= wr_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_sram_model_param.sv
// Directed bench for sram_model_param: three instances (LAT1/REC0, LAT3/REC2, LAT2/REC0)
// share one stimulus set; ce and io drive are steered to the instance under test.
module tb_sram_model_param;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int          sel;
  logic        ce, oe, we, drv_en;
  logic [1:0]  be;
  logic [15:0] a, drv;
  int          total = 0;
  int          bad   = 0;

  sram_model_param_if #(.DW(16), .AW(16)) if0 ();
  sram_model_param_if #(.DW(16), .AW(16)) if1 ();
  sram_model_param_if #(.DW(16), .AW(16)) if2 ();

  wire [15:0] io0, io1, io2;

  assign if0.ce = (sel == 0) ? ce : 1'b1;
  assign if1.ce = (sel == 1) ? ce : 1'b1;
  assign if2.ce = (sel == 2) ? ce : 1'b1;
  assign if0.oe = oe;  assign if1.oe = oe;  assign if2.oe = oe;
  assign if0.we = we;  assign if1.we = we;  assign if2.we = we;
  assign if0.be = be;  assign if1.be = be;  assign if2.be = be;
  assign if0.a  = a;   assign if1.a  = a;   assign if2.a  = a;

  assign io0 = (drv_en && sel == 0) ? drv : 16'hzzzz;
  assign io1 = (drv_en && sel == 1) ? drv : 16'hzzzz;
  assign io2 = (drv_en && sel == 2) ? drv : 16'hzzzz;

  // Undriven lanes read back as all-ones.
  for (genvar i = 0; i < 16; i++) begin : g_pu
    pullup (io0[i]);
    pullup (io1[i]);
    pullup (io2[i]);
  end

`ifdef SRAM_STATS_EN
  logic [31:0] rc0, wc0, rc1, wc1, rc2, wc2;
`endif

  sram_model_param #(.DW(16), .AW(16), .READ_LAT(1), .WR_REC(0)) u0 (
    .clk(clk), .rst_n(rst_n), .bus(if0.slave), .io(io0)
`ifdef SRAM_STATS_EN
    , .rd_cnt(rc0), .wr_cnt(wc0)
`endif
  );
  sram_model_param #(.DW(16), .AW(16), .READ_LAT(3), .WR_REC(2)) u1 (
    .clk(clk), .rst_n(rst_n), .bus(if1.slave), .io(io1)
`ifdef SRAM_STATS_EN
    , .rd_cnt(rc1), .wr_cnt(wc1)
`endif
  );
  sram_model_param #(.DW(16), .AW(16), .READ_LAT(2), .WR_REC(0)) u2 (
    .clk(clk), .rst_n(rst_n), .bus(if2.slave), .io(io2)
`ifdef SRAM_STATS_EN
    , .rd_cnt(rc2), .wr_cnt(wc2)
`endif
  );

  typedef struct {
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [1:0]  wbe;
    logic [1:0]  rbe;
    logic [15:0] exp_io;
    logic        exp_vld;
  } vec_t;

  vec_t vt [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ce = 1'b1; we = 1'b1; oe = 1'b0; be = 2'b00; drv_en = 1'b0;
    #1;
  endtask

  task automatic write_req(input logic [15:0] addr, input logic [15:0] data, input logic [1:0] b);
    ce = 1'b0; we = 1'b0; oe = 1'b1; a = addr; be = b; drv = data; drv_en = 1'b1;
  endtask

  task automatic read_req(input logic [15:0] addr, input logic [1:0] b);
    ce = 1'b0; we = 1'b1; oe = 1'b0; a = addr; be = b; drv_en = 1'b0;
  endtask

  task automatic write(input logic [15:0] addr, input logic [15:0] data, input logic [1:0] b);
    write_req(addr, data, b);
    cyc();
    idle();
  endtask

  task automatic read(input logic [15:0] addr, input logic [1:0] b);
    read_req(addr, b);
    cyc();
    idle();
  endtask

  function automatic logic cur_ready();
    case (sel)
      0:       return if0.ready;
      1:       return if1.ready;
      default: return if2.ready;
    endcase
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (cur_ready() !== 1'b1 && n < 20) begin
      cyc();
      n++;
    end
    check("wait_ready", {31'd0, cur_ready()}, 32'd1);
  endtask

  initial begin
    sel = 0; ce = 1'b1; oe = 1'b1; we = 1'b1; be = 2'b00; a = '0; drv = '0; drv_en = 1'b0;

    vt[0] = '{16'h0010, 16'hA5C3, 2'b00, 2'b00, 16'hA5C3, 1'b1};
    vt[1] = '{16'h0020, 16'h1122, 2'b00, 2'b00, 16'h1122, 1'b1};
    vt[2] = '{16'h0020, 16'hFF33, 2'b10, 2'b00, 16'h1133, 1'b1};
    vt[3] = '{16'h0020, 16'h0000, 2'b11, 2'b01, 16'h11FF, 1'b1};
    vt[4] = '{16'h0010, 16'h00EE, 2'b10, 2'b10, 16'hFFEE, 1'b1};
    vt[5] = '{16'hFFFF, 16'h1234, 2'b00, 2'b00, 16'h1234, 1'b1};
    vt[6] = '{16'h0000, 16'h8001, 2'b00, 2'b00, 16'h8001, 1'b1};
    vt[7] = '{16'h0020, 16'h0000, 2'b11, 2'b11, 16'hFFFF, 1'b1};

    #12;
    check("rst_ready0", {31'd0, if0.ready},  32'd1);
    check("rst_rdvld0", {31'd0, if0.rd_vld}, 32'd0);
    check("rst_err0",   {31'd0, if0.err},    32'd0);
    check("rst_io0",    {16'd0, io0},        32'h0000FFFF);
    check("rst_ready1", {31'd0, if1.ready},  32'd1);
    rst_n = 1'b1;
    idle();

    for (int i = 0; i < 8; i++) begin
      write(vt[i].addr, vt[i].wdata, vt[i].wbe);
      read(vt[i].addr, vt[i].rbe);
      check($sformatf("vec%0d_io", i),  {16'd0, io0},        {16'd0, vt[i].exp_io});
      check($sformatf("vec%0d_vld", i), {31'd0, if0.rd_vld}, {31'd0, vt[i].exp_vld});
      cyc();
      check($sformatf("vec%0d_after", i), {31'd0, if0.rd_vld}, 32'd0);
    end
    check("tbl_err", {31'd0, if0.err}, 32'd0);

    // Output stage valid while oe is high: dropped silently.
    read_req(16'h0010, 2'b00);
    cyc();
    ce = 1'b1; we = 1'b1; oe = 1'b1;
    #1;
    check("oe_drop_vld", {31'd0, if0.rd_vld}, 32'd0);
    check("oe_drop_io",  {16'd0, io0},        32'h0000FFFF);
    cyc();
    idle();
    check("oe_drop_err", {31'd0, if0.err}, 32'd0);

    // Write recovery with an access during the busy window.
    sel = 1;
    idle();
    write(16'h0040, 16'h0BEE, 2'b00);
    check("rec_ready_w", {31'd0, if1.ready}, 32'd0);
    read_req(16'h0040, 2'b00);
    cyc();
    check("rec_err",     {31'd0, if1.err},   32'd1);
    check("rec_ready_r", {31'd0, if1.ready}, 32'd0);
    write_req(16'h0040, 16'hDEAD, 2'b00);
    cyc();
    idle();
    check("rec_ready_back", {31'd0, if1.ready}, 32'd1);
    cyc();
    check("rec_ign_vld_a", {31'd0, if1.rd_vld}, 32'd0);
    cyc();
    check("rec_ign_vld_b", {31'd0, if1.rd_vld}, 32'd0);
    read(16'h0040, 2'b00);
    cyc();
    cyc();
    check("rec_mem_io",  {16'd0, io1},        32'h00000BEE);
    check("rec_mem_vld", {31'd0, if1.rd_vld}, 32'd1);
    cyc();

    // READ_LAT=3 back-to-back reads.
    write(16'h0001, 16'h1111, 2'b00); wait_ready();
    write(16'h0002, 16'h2222, 2'b00); wait_ready();
    write(16'h0003, 16'h3333, 2'b00); wait_ready();
    read_req(16'h0001, 2'b00); cyc();
    check("b2b_vld_c1", {31'd0, if1.rd_vld}, 32'd0);
    read_req(16'h0002, 2'b00); cyc();
    check("b2b_vld_c2", {31'd0, if1.rd_vld}, 32'd0);
    read_req(16'h0003, 2'b00); cyc();
    idle();
    check("b2b_d1", {16'd0, io1}, 32'h00001111);
    check("b2b_v1", {31'd0, if1.rd_vld}, 32'd1);
    cyc();
    check("b2b_d2", {16'd0, io1}, 32'h00002222);
    check("b2b_v2", {31'd0, if1.rd_vld}, 32'd1);
    cyc();
    check("b2b_d3", {16'd0, io1}, 32'h00003333);
    check("b2b_v3", {31'd0, if1.rd_vld}, 32'd1);
    cyc();
    check("b2b_end", {31'd0, if1.rd_vld}, 32'd0);

    // READ_LAT=2 snapshot and write/output collision.
    sel = 2;
    idle();
    write(16'h0050, 16'hAAAA, 2'b00);
    read_req(16'h0050, 2'b00); cyc();
    write_req(16'h0050, 16'hBBBB, 2'b00); cyc();
    idle();
    check("snap_io",  {16'd0, io2},        32'h0000AAAA);
    check("snap_vld", {31'd0, if2.rd_vld}, 32'd1);
    check("snap_err", {31'd0, if2.err},    32'd0);
    cyc();
    read(16'h0050, 2'b00);
    cyc();
    check("snap_new", {16'd0, io2}, 32'h0000BBBB);
    cyc();
    read(16'h0050, 2'b00);
    cyc();
    write_req(16'h0050, 16'hCCCC, 2'b00);
    #1;
    check("coll_nodrive", {31'd0, if2.rd_vld}, 32'd0);
    cyc();
    idle();
    check("coll_err", {31'd0, if2.err}, 32'd1);
    read(16'h0050, 2'b00);
    cyc();
    check("coll_mem", {16'd0, io2}, 32'h0000CCCC);
    cyc();

    // Asynchronous reset with the read pipeline full.
    sel = 1;
    idle();
    read_req(16'h0001, 2'b00); cyc();
    read_req(16'h0002, 2'b00); cyc();
    read_req(16'h0003, 2'b00); cyc();
    idle();
    check("pre_rst_vld", {31'd0, if1.rd_vld}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_io",    {16'd0, io1},        32'h0000FFFF);
    check("mid_rst_vld",   {31'd0, if1.rd_vld}, 32'd0);
    check("mid_rst_err1",  {31'd0, if1.err},    32'd0);
    check("mid_rst_err2",  {31'd0, if2.err},    32'd0);
    check("mid_rst_ready", {31'd0, if1.ready},  32'd1);
    #3;
    rst_n = 1'b1;
    cyc();
    check("post_rst_vld", {31'd0, if1.rd_vld}, 32'd0);
    read(16'h0002, 2'b00);
    cyc();
    cyc();
    check("retain_io",  {16'd0, io1},        32'h00002222);
    check("retain_vld", {31'd0, if1.rd_vld}, 32'd1);
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
